vend_sequencer: RTL

Control block for the soda vending datapath. It accumulates coin credit and requests a product from the dispenser through a req/ack handshake. It then pays out change one nickel at a time through a coin-hopper handshake. It also handles customer coin-return requests and dispenser timeouts by refunding the full credit.

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_sequencer_if.sv | 25 ++
 rtl/vend_coin_decode.sv | 27 ++
 rtl/vend_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the soda vending sequencer.
package vend_pkg;

    // Credit register width; MAX_CREDIT never exceeds 60 cents.
    localparam int unsigned CREDIT_W = 6;

    // Coin denominations in cents.
    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE
    } vend_state_t;

endpackage

// File: rtl/vend_sequencer_if.sv
// Dispenser and coin-hopper req/ack handshakes of the vending sequencer.
interface vend_sequencer_if;

    logic disp_req;
    logic disp_ack;
    logic hop_req;
    logic hop_ack;

    // Sequencer side: issues requests, receives acknowledges.
    modport master (
        output disp_req,
        output hop_req,
        input  disp_ack,
        input  hop_ack
    );

    // Dispenser/hopper side.
    modport slave (
        input  disp_req,
        input  hop_req,
        output disp_ack,
        output hop_ack
    );

endinterface

// File: rtl/vend_coin_decode.sv
// Priority decode of the coin pulses: quarter > dime > nickel.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    output logic                coin_valid,
    output logic [CREDIT_W-1:0] value,
    output logic                multi_coin
);

    // Select the highest-value coin and flag simultaneous inserts.
    always_comb begin
        value = '0;
        if (quarter) begin
            value = QUARTER_C;
        end else if (dime) begin
            value = DIME_C;
        end else if (nickel) begin
            value = NICKEL_C;
        end
        coin_valid = nickel | dime | quarter;
        multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending control: credit accumulation, dispense handshake with timeout,
// and nickel-by-nickel change/refund payout.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = 20,
    parameter int unsigned MAX_CREDIT = 40,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                coin_return,
    vend_sequencer_if.master    hs,
    output logic                soda,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT);
    // Last counter value with disp_req still high; expiry fires on this cycle.
    localparam logic [7:0]          TO_LAST = 8'(TIMEOUT - 1);

    vend_state_t         state, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [7:0]          cnt_q, cnt_n;
    logic                disp_req_q, disp_req_n;
    logic                hop_req_q, hop_req_n;
    logic                soda_q, soda_n;
    logic                reject_q, reject_n;
    logic                busy_q, busy_n;
    logic                fault_q, fault_n;

    logic                coin_valid;
    logic                multi_coin;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W:0]   sum;
    logic                coin_window;
    logic                coin_ok;

    vend_coin_decode u_decode (
        .nickel     (nickel),
        .dime       (dime),
        .quarter    (quarter),
        .coin_valid (coin_valid),
        .value      (coin_value),
        .multi_coin (multi_coin)
    );

    // Next-state, next-credit and next-output computation.
    always_comb begin
        state_n    = state;
        credit_n   = credit_q;
        cnt_n      = '0;
        soda_n     = 1'b0;
        reject_n   = 1'b0;
        fault_n    = fault_q;
        coin_ok    = 1'b0;
        sum        = {1'b0, credit_q} + {1'b0, coin_value};
        coin_window = (state == IDLE) ||
                      ((state == COLLECT) && (credit_q < PRICE_C));

        if (coin_valid) begin
            if (coin_window && (sum <= MAX_C)) begin
                coin_ok = 1'b1;
            end else begin
                reject_n = 1'b1;
            end
        end
        if (multi_coin) begin
            reject_n = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (coin_ok) begin
                    credit_n = sum[CREDIT_W-1:0];
                    state_n  = COLLECT;
                end
            end
            COLLECT: begin
                if (credit_q >= PRICE_C) begin
                    state_n = DISPENSE;
                end else begin
                    if (coin_ok) begin
                        credit_n = sum[CREDIT_W-1:0];
                    end
                    if (coin_return) begin
                        state_n = CHANGE;
                    end
                end
            end
            DISPENSE: begin
                // Ack is checked before expiry so a same-cycle ack still vends.
                if (disp_req_q && hs.disp_ack) begin
                    credit_n = credit_q - PRICE_C;
                    soda_n   = 1'b1;
                    state_n  = (credit_n != '0) ? CHANGE : IDLE;
                end else if (cnt_q == TO_LAST) begin
                    fault_n = 1'b1;
                    state_n = CHANGE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            CHANGE: begin
                if (hop_req_q && hs.hop_ack && (credit_q != '0)) begin
                    credit_n = credit_q - NICKEL_C;
                end
                if (credit_n == '0) begin
                    state_n = IDLE;
                end
            end
        endcase

        // Outputs are derived from the next state so they register with it.
        disp_req_n = (state_n == DISPENSE);
        hop_req_n  = (state_n == CHANGE) && (credit_n != '0);
        busy_n     = (state_n == DISPENSE) || (state_n == CHANGE);
    end

    // State, credit, counter and registered-output storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            credit_q   <= '0;
            cnt_q      <= '0;
            disp_req_q <= 1'b0;
            hop_req_q  <= 1'b0;
            soda_q     <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_n;
            credit_q   <= credit_n;
            cnt_q      <= cnt_n;
            disp_req_q <= disp_req_n;
            hop_req_q  <= hop_req_n;
            soda_q     <= soda_n;
            reject_q   <= reject_n;
            busy_q     <= busy_n;
            fault_q    <= fault_n;
        end
    end

    assign hs.disp_req = disp_req_q;
    assign hs.hop_req  = hop_req_q;
    assign soda        = soda_q;
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule
